ysyx_22050058_mem: RTL and testbench

YSYX_22050058_MEM -- requirements
Module: ysyx_22050058_mem

---
 rtl/ysyx_22050058_mem_pkg.sv | 38 +++
 rtl/ysyx_22050058_lsu_align.sv | 84 ++++++++
 rtl/ysyx_22050058_mem.sv | 135 +++++++++++++
 tb/tb_ysyx_22050058_mem.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050058_mem_pkg.sv
// Shared widths, ALU op codes and MEM-stage FSM encodings for the ysyx_22050058 core.
package ysyx_22050058_mem_pkg;

  localparam int XLEN      = 64;
  localparam int ALUOP_W   = 8;
  localparam int REG_AW    = 5;
  localparam int NUM_LANES = XLEN / 8;

  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALU_NOP = 8'h00;
  localparam aluop_t ALU_ADD = 8'h01;
  localparam aluop_t ALU_LB  = 8'h20;
  localparam aluop_t ALU_LH  = 8'h21;
  localparam aluop_t ALU_LW  = 8'h22;
  localparam aluop_t ALU_LD  = 8'h23;
  localparam aluop_t ALU_LBU = 8'h24;
  localparam aluop_t ALU_LHU = 8'h25;
  localparam aluop_t ALU_LWU = 8'h26;
  localparam aluop_t ALU_SB  = 8'h28;
  localparam aluop_t ALU_SH  = 8'h29;
  localparam aluop_t ALU_SW  = 8'h2A;
  localparam aluop_t ALU_SD  = 8'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                 wen;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic [NUM_LANES-1:0] wmask;
  } dmem_req_t;

endpackage

// File: rtl/ysyx_22050058_lsu_align.sv
// Combinational load lane select / extension and store replication / byte-mask generation.
module ysyx_22050058_lsu_align
  import ysyx_22050058_mem_pkg::*;
(
  input  aluop_t               op,
  input  logic [2:0]           off,
  input  logic [XLEN-1:0]      rdata,
  input  logic [XLEN-1:0]      sdata,
  output logic [XLEN-1:0]      ldata,
  output logic [XLEN-1:0]      wdata,
  output logic [NUM_LANES-1:0] wmask,
  output logic                 is_load,
  output logic                 is_store,
  output logic                 misaligned
);

  logic [1:0]           size;  // log2 of access bytes
  logic                 sext;
  logic [XLEN-1:0]      shifted;
  logic [NUM_LANES-1:0] base_mask;

  // Decode depends on op only, kept apart from the offset path to avoid a comb loop upstream.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    sext     = 1'b0;
    case (op)
      ALU_LB:  begin is_load  = 1'b1; size = 2'd0; sext = 1'b1; end
      ALU_LH:  begin is_load  = 1'b1; size = 2'd1; sext = 1'b1; end
      ALU_LW:  begin is_load  = 1'b1; size = 2'd2; sext = 1'b1; end
      ALU_LD:  begin is_load  = 1'b1; size = 2'd3; end
      ALU_LBU: begin is_load  = 1'b1; size = 2'd0; end
      ALU_LHU: begin is_load  = 1'b1; size = 2'd1; end
      ALU_LWU: begin is_load  = 1'b1; size = 2'd2; end
      ALU_SB:  begin is_store = 1'b1; size = 2'd0; end
      ALU_SH:  begin is_store = 1'b1; size = 2'd1; end
      ALU_SW:  begin is_store = 1'b1; size = 2'd2; end
      ALU_SD:  begin is_store = 1'b1; size = 2'd3; end
      default: ;
    endcase
  end

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    ldata = '0;
    if (is_load) begin
      case (size)
        2'd0: ldata = sext ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
        2'd1: ldata = sext ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
        2'd2: ldata = sext ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
        default: ldata = shifted;
      endcase
    end
  end

  always_comb begin
    wdata     = sdata;
    base_mask = 8'hFF;
    case (size)
      2'd0: begin wdata = {8{sdata[7:0]}};  base_mask = 8'h01; end
      2'd1: begin wdata = {4{sdata[15:0]}}; base_mask = 8'h03; end
      2'd2: begin wdata = {2{sdata[31:0]}}; base_mask = 8'h0F; end
      default: ;
    endcase
  end

  // Shifting in 8 bits drops lanes past the doubleword boundary.
  assign wmask = is_store ? (base_mask << off) : '0;

  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      case (size)
        2'd1:    misaligned = off[0];
        2'd2:    misaligned = |off[1:0];
        2'd3:    misaligned = |off;
        default: misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050058_mem.sv
// MEM stage: issues one dmem request per load/store and stalls until the result is ready.
// Define YSYX_22050058_MISALIGN_CHK_EN to suppress misaligned accesses and flag them on mem_misalign_o.
module ysyx_22050058_mem
  import ysyx_22050058_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      mem_pc_i,
  input  logic [XLEN-1:0]      mem_dnpc_i,
  input  logic                 mem_dpicstop_i,
  input  logic                 mem_instvalid_i,
  input  logic                 mem_we_i,
  input  aluop_t               mem_aluop_i,
  input  logic [REG_AW-1:0]    mem_reg_waddr_i,
  input  logic [XLEN-1:0]      mem_wdata_i,
  input  logic [XLEN-1:0]      mem_addr_i,
  output logic                 dmem_req_o,
  output logic                 dmem_wen_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  output logic [NUM_LANES-1:0] dmem_wmask_o,
  input  logic                 dmem_ack_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic                 mem_stall_memreq_o,
`ifdef YSYX_22050058_MISALIGN_CHK_EN
  output logic                 mem_misalign_o,
`endif
  output logic [XLEN-1:0]      mem_pc_o,
  output logic [XLEN-1:0]      mem_dnpc_o,
  output logic                 mem_dpicstop_o,
  output logic                 mem_instvalid_o,
  output logic                 mem_we_o,
  output logic [REG_AW-1:0]    mem_reg_waddr_o,
  output logic [XLEN-1:0]      mem_wdata_o
);

  mem_state_e           state;
  dmem_req_t            req_q, req_cur, req_out;
  aluop_t               op_q, op_sel;
  logic [2:0]           off_q, off_sel;
  logic [XLEN-1:0]      rdata_q, eff_addr, ldata, st_wdata;
  logic [NUM_LANES-1:0] st_wmask;
  logic                 is_load, is_store, misaligned, mem_op, idle, issue, mis_flag;

  assign idle     = (state == ST_IDLE);
  assign op_sel   = idle ? mem_aluop_i : op_q;
  assign eff_addr = is_store ? mem_addr_i : mem_wdata_i;
  assign off_sel  = idle ? eff_addr[2:0] : off_q;
  assign mem_op   = is_load | is_store;

  ysyx_22050058_lsu_align u_align (
    .op         (op_sel),
    .off        (off_sel),
    .rdata      (rdata_q),
    .sdata      (mem_wdata_i),
    .ldata      (ldata),
    .wdata      (st_wdata),
    .wmask      (st_wmask),
    .is_load    (is_load),
    .is_store   (is_store),
    .misaligned (misaligned)
  );

`ifdef YSYX_22050058_MISALIGN_CHK_EN
  assign mis_flag       = rst_n & idle & mem_instvalid_i & misaligned;
  assign mem_misalign_o = mis_flag;
`else
  assign mis_flag = 1'b0;
`endif

  assign issue = rst_n & idle & mem_instvalid_i & mem_op & ~mis_flag;

  assign req_cur = '{wen:   is_store,
                     addr:  {eff_addr[XLEN-1:3], 3'b000},
                     wdata: st_wdata,
                     wmask: st_wmask};

  // Issue cycle drives live decode; WAIT replays the captured request so it cannot drift.
  always_comb begin
    dmem_req_o = 1'b0;
    req_out    = '0;
    if (issue) begin
      dmem_req_o = 1'b1;
      req_out    = req_cur;
    end else if (rst_n && state == ST_WAIT) begin
      dmem_req_o = 1'b1;
      req_out    = req_q;
    end
  end

  assign dmem_wen_o         = req_out.wen;
  assign dmem_addr_o        = req_out.addr;
  assign dmem_wdata_o       = req_out.wdata;
  assign dmem_wmask_o       = req_out.wmask;
  assign mem_stall_memreq_o = dmem_req_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      op_q    <= ALU_NOP;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (issue) begin
          req_q <= req_cur;
          op_q  <= mem_aluop_i;
          off_q <= eff_addr[2:0];
          state <= ST_WAIT;
        end
        ST_WAIT: if (dmem_ack_i) begin
          rdata_q <= dmem_rdata_i;
          state   <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wdata_o = mem_wdata_i;
    if (state == ST_DONE)                mem_wdata_o = ldata;
    else if (state == ST_WAIT)           mem_wdata_o = '0;
    else if (mem_instvalid_i && mem_op)  mem_wdata_o = '0;
  end

  assign mem_we_o        = mem_we_i & ~is_store & ~mis_flag;
  assign mem_pc_o        = mem_pc_i;
  assign mem_dnpc_o      = mem_dnpc_i;
  assign mem_dpicstop_o  = mem_dpicstop_i;
  assign mem_instvalid_o = mem_instvalid_i;
  assign mem_reg_waddr_o = mem_reg_waddr_i;

endmodule

// File: tb/tb_ysyx_22050058_mem.sv
// Directed bench for the MEM stage: passthrough, load/store formatting, wait hold, reset abort.
module tb_ysyx_22050058_mem;
  import ysyx_22050058_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc_i, dnpc_i, wdata_i, addr_i, rdata_i;
  logic        dpicstop_i, instvalid_i, we_i, ack_i;
  aluop_t      aluop_i;
  logic [4:0]  waddr_i;
  logic        req_o, wen_o, stall_o, dpicstop_o, instvalid_o, we_o;
  logic [63:0] daddr_o, dwdata_o, pc_o, dnpc_o, wdata_o;
  logic [7:0]  wmask_o;
  logic [4:0]  waddr_o;
`ifdef YSYX_22050058_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int ntotal = 0, npass = 0, nfail = 0;

  always #5 clk = ~clk;

  ysyx_22050058_mem dut (
    .clk(clk), .rst_n(rst_n),
    .mem_pc_i(pc_i), .mem_dnpc_i(dnpc_i),
    .mem_dpicstop_i(dpicstop_i), .mem_instvalid_i(instvalid_i), .mem_we_i(we_i),
    .mem_aluop_i(aluop_i), .mem_reg_waddr_i(waddr_i),
    .mem_wdata_i(wdata_i), .mem_addr_i(addr_i),
    .dmem_req_o(req_o), .dmem_wen_o(wen_o), .dmem_addr_o(daddr_o),
    .dmem_wdata_o(dwdata_o), .dmem_wmask_o(wmask_o),
    .dmem_ack_i(ack_i), .dmem_rdata_i(rdata_i),
    .mem_stall_memreq_o(stall_o),
`ifdef YSYX_22050058_MISALIGN_CHK_EN
    .mem_misalign_o(misalign_o),
`endif
    .mem_pc_o(pc_o), .mem_dnpc_o(dnpc_o), .mem_dpicstop_o(dpicstop_o),
    .mem_instvalid_o(instvalid_o), .mem_we_o(we_o),
    .mem_reg_waddr_o(waddr_o), .mem_wdata_o(wdata_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks run mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input aluop_t op, input logic [63:0] wd, input logic [63:0] ad);
    aluop_i = op; wdata_i = wd; addr_i = ad; instvalid_i = 1'b1; we_i = 1'b1;
  endtask

  // Load with ack on the first WAIT cycle: result appears two cycles after issue.
  task automatic do_load(input string tag, input aluop_t op, input logic [63:0] ea,
                         input logic [63:0] rd, input logic [63:0] exp);
    cyc(); set_op(op, ea, 64'h0); #4;
    chk({tag, "_req"}, {63'd0, req_o}, 64'd1);
    cyc(); ack_i = 1'b1; rdata_i = rd; #4;
    cyc(); ack_i = 1'b0; rdata_i = 64'h0; #4;
    chk({tag, "_stall_done"}, {63'd0, stall_o}, 64'd0);
    chk({tag, "_data"}, wdata_o, exp);
  endtask

  task automatic do_store(input string tag, input aluop_t op, input logic [63:0] ea,
                          input logic [63:0] sd, input logic [7:0] mask, input logic [63:0] wd);
    cyc(); set_op(op, sd, ea); #4;
    chk({tag, "_wen"}, {63'd0, wen_o}, 64'd1);
    chk({tag, "_mask"}, {56'd0, wmask_o}, {56'd0, mask});
    chk({tag, "_wdata"}, dwdata_o, wd);
    cyc(); ack_i = 1'b1; #4;
    cyc(); ack_i = 1'b0; #4;
    chk({tag, "_we_o"}, {63'd0, we_o}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; ack_i = 1'b0; rdata_i = '0;
    pc_i = 64'h8000_0100; dnpc_i = 64'h8000_0104; dpicstop_i = 1'b1; waddr_i = 5'd7;
    set_op(ALU_LD, 64'h8000_0000, 64'h0);
    cyc(); cyc(); #4;
    chk("rst_req", {63'd0, req_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_wen", {63'd0, wen_o}, 64'd0);
    chk("rst_wmask", {56'd0, wmask_o}, 64'd0);

    // Non-memory op passes through in the same cycle; ack in IDLE is ignored.
    cyc(); rst_n = 1'b1; set_op(ALU_ADD, 64'h5, 64'h0); ack_i = 1'b1; #4;
    chk("add_wdata", wdata_o, 64'h5);
    chk("add_req", {63'd0, req_o}, 64'd0);
    chk("add_stall", {63'd0, stall_o}, 64'd0);
    chk("add_we", {63'd0, we_o}, 64'd1);
    chk("pass_pc", pc_o, 64'h8000_0100);
    chk("pass_dnpc", dnpc_o, 64'h8000_0104);
    chk("pass_waddr", {59'd0, waddr_o}, 64'd7);
    chk("pass_flags", {62'd0, dpicstop_o, instvalid_o}, 64'd3);
    cyc(); ack_i = 1'b0; #4;
    chk("idle_ack_stall", {63'd0, stall_o}, 64'd0);

    // LB, ack two cycles after issue: stall for three cycles, then result.
    cyc(); set_op(ALU_LB, 64'h8000_0003, 64'h0); #4;
    chk("lb_req", {63'd0, req_o}, 64'd1);
    chk("lb_stall0", {63'd0, stall_o}, 64'd1);
    chk("lb_addr", daddr_o, 64'h8000_0000);
    chk("lb_wen", {63'd0, wen_o}, 64'd0);
    cyc(); #4;
    chk("lb_stall1", {63'd0, stall_o}, 64'd1);
    cyc(); ack_i = 1'b1; rdata_i = 64'h0000_0000_80FF_0000; #4;
    chk("lb_stall2", {63'd0, stall_o}, 64'd1);
    cyc(); ack_i = 1'b0; rdata_i = '0; #4;
    chk("lb_stall3", {63'd0, stall_o}, 64'd0);
    chk("lb_req3", {63'd0, req_o}, 64'd0);
    chk("lb_data", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_we", {63'd0, we_o}, 64'd1);

    do_load("lhu", ALU_LHU, 64'h8000_0006, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    do_load("lw",  ALU_LW,  64'h8000_0004, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
    do_load("lwu", ALU_LWU, 64'h8000_0004, 64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001);
    do_load("ld",  ALU_LD,  64'h8000_0008, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);

    // SW with ack held off 10 cycles; inputs wander but the request must not.
    cyc(); set_op(ALU_SW, 64'h1122_3344, 64'h8000_0004); #4;
    chk("sw_addr", daddr_o, 64'h8000_0000);
    chk("sw_mask", {56'd0, wmask_o}, 64'hF0);
    chk("sw_wdata", dwdata_o, 64'h1122_3344_1122_3344);
    chk("sw_we_o", {63'd0, we_o}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(); wdata_i = 64'hDEAD_0000 + 64'(i); addr_i = 64'h9000_0000 + 64'(i); #4;
      chk("sw_hold_addr", daddr_o, 64'h8000_0000);
      chk("sw_hold_wdata", dwdata_o, 64'h1122_3344_1122_3344);
      chk("sw_hold_mask", {56'd0, wmask_o}, 64'hF0);
      chk("sw_hold_stall", {63'd0, stall_o}, 64'd1);
    end
    cyc(); ack_i = 1'b1; #4;
    cyc(); ack_i = 1'b0; #4;
    chk("sw_done_stall", {63'd0, stall_o}, 64'd0);
    chk("sw_done_we", {63'd0, we_o}, 64'd0);

    do_store("sb", ALU_SB, 64'h8000_0005, 64'h0000_00AB, 8'h20, 64'hABAB_ABAB_ABAB_ABAB);
    do_store("sh", ALU_SH, 64'h8000_0002, 64'h0000_BEEF, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF);
    do_store("sd", ALU_SD, 64'h8000_0008, 64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708);

    // Reset during WAIT aborts the LD; a late ack is discarded.
    cyc(); set_op(ALU_LD, 64'h8000_0010, 64'h0); #4;
    chk("rstw_req", {63'd0, req_o}, 64'd1);
    cyc(); rst_n = 1'b0; set_op(ALU_ADD, 64'h77, 64'h0); #4;
    chk("rstw_req_low", {63'd0, req_o}, 64'd0);
    chk("rstw_stall_low", {63'd0, stall_o}, 64'd0);
    cyc(); rst_n = 1'b1; ack_i = 1'b1; rdata_i = 64'h1234; #4;
    chk("rstw_req_after", {63'd0, req_o}, 64'd0);
    chk("rstw_wdata", wdata_o, 64'h77);
    cyc(); ack_i = 1'b0; #4;
    chk("rstw_no_done", wdata_o, 64'h77);
    chk("rstw_stall_after", {63'd0, stall_o}, 64'd0);

    // Invalid op never issues.
    cyc(); set_op(ALU_LD, 64'h8000_0000, 64'h0); instvalid_i = 1'b0; #4;
    chk("inv_req", {63'd0, req_o}, 64'd0);
    chk("inv_stall", {63'd0, stall_o}, 64'd0);

`ifdef YSYX_22050058_MISALIGN_CHK_EN
    cyc(); set_op(ALU_LW, 64'h8000_0002, 64'h0); #4;
    chk("mis_req", {63'd0, req_o}, 64'd0);
    chk("mis_stall", {63'd0, stall_o}, 64'd0);
    chk("mis_flag", {63'd0, misalign_o}, 64'd1);
    chk("mis_we", {63'd0, we_o}, 64'd0);
    chk("mis_wdata", wdata_o, 64'h0);
    cyc(); set_op(ALU_ADD, 64'h9, 64'h0); #4;
    chk("mis_flag_clr", {63'd0, misalign_o}, 64'd0);
`else
    do_store("sw_mis", ALU_SW, 64'h8000_0002, 64'hCAFE_F00D, 8'h3C, 64'hCAFE_F00D_CAFE_F00D);
    do_store("sd_mis", ALU_SD, 64'h8000_0003, 64'h0, 8'hF8, 64'h0);
`endif

    cyc();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
